ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

EX/MEM boundary stage of the 5-stage pipelined LEGv8 CPU, directly downstream of the 64-bit ALU. It latches the ALU result and control bundle into the MEM stage and owns the architectural NZCV flag register, written by flag-setting instructions (ADDS/SUBS). It also resolves conditional and compare branches (B.cond, CBZ, CBNZ) and unconditional B, and produces a registered branch-taken indication for the fetch redirect logic.

## Interface
Parameters:
- DATA_W, 64, datapath width; must equal the ALU width.
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  downstream hold; stage registers and flags keep their values.
- flush  in  1  squash the instruction currently in EX.
- ex_valid  in  1  EX holds a real instruction.
- alu_result  in  DATA_W  ALU result.
- alu_negative, alu_zero, alu_overflow, alu_carry_out  in  1 each  ALU flags for the current EX operation.
- ex_set_flags  in  1  instruction updates NZCV.
- ex_br_type  in  2  branch type: 00 none, 01 CBZ, 10 CBNZ, 11 B.cond / B.
- ex_cond  in  4  ARM condition code, used when ex_br_type=11.
- ex_store_data  in  DATA_W  STUR data.
- ex_rd  in  REG_AW  destination register.
- ex_reg_write, ex_mem_read, ex_mem_write  in  1 each  control bits.
- mem_valid  out  1  MEM holds a real instruction.
- mem_alu_result, mem_store_data  out  DATA_W  latched values.
- mem_rd  out  REG_AW; mem_reg_write, mem_mem_read, mem_mem_write  out  1 each.
- mem_branch_taken  out  1  registered branch resolution.
- flags_nzcv  out  4  architectural flags {N,Z,C,V}.

## Operation
- Advance: when stall=0 and flush=0, all mem_* registers load from their ex_* / alu_* sources, and mem_valid<=ex_valid.
- Squash: flush=1 sets mem_valid<=0 and clears mem_reg_write, mem_mem_read, mem_mem_write and mem_branch_taken. Data fields are don't-care. Flags are not written.
- Flush has priority over stall. With stall=1 and flush=0, every register holds.
- Flag write: when ex_valid=1, ex_set_flags=1, stall=0 and flush=0, flags_nzcv<={alu_negative, alu_zero, alu_carry_out, alu_overflow}. No other condition writes the flags.
- Branch resolution, computed combinationally from EX inputs and latched into mem_branch_taken; forced to 0 when ex_valid=0:
  - CBZ: taken = alu_zero. The ALU runs PASS_B on Rt.
  - CBNZ: taken = ~alu_zero.
  - B.cond: evaluated against the current flags_nzcv register, not the ALU flags.
    - EQ 0000: Z. NE 0001: ~Z. HS 0010: C. LO 0011: ~C. MI 0100: N. PL 0101: ~N. VS 0110: V. VC 0111: ~V.
    - HI 1000: C&~Z. LS 1001: ~C|Z. GE 1010: N==V. LT 1011: N!=V. GT 1100: ~Z&(N==V). LE 1101: Z|(N!=V).
    - AL 1110 and 1111: always taken. Unconditional B is encoded as AL.
- Flag-setter followed by B.cond: the setter writes the flags at the edge it leaves EX, so the next instruction sees the updated flags with no bubble.
- An instruction that both sets flags and branches evaluates its condition on the pre-update flags.

## Timing
- Latency: 1 cycle from EX inputs to mem_* outputs and mem_branch_taken. Flags are visible 1 cycle after the setter's advance edge.
- Reset is asynchronous and immediate. All outputs go to 0: mem_valid=0, all data and control fields 0, mem_branch_taken=0, flags_nzcv=4'b0000.
- Reset deasserting mid-stall: the stage stays empty until the first advancing edge.
- No combinational path from any input to any output.

## Structure
- Shared package cpu_pkg:
  - br_type_t enum (BR_NONE, BR_CBZ, BR_CBNZ, BR_COND).
  - cond_t constants EQ..AL.
  - ALU control constants (ALU_PASS_B=000, ALU_ADD=010, ALU_SUBTRACT=011, ALU_AND=100, ALU_OR=101, ALU_XOR=110).
  - nzcv_t packed struct.
- One sub-module, cond_check: purely combinational, inputs cond[3:0] and nzcv[3:0], output taken. It is instantiated once for B.cond.

## Test plan
- Reset: assert reset mid-cycle with mem_valid=1 -> all outputs 0 and flags_nzcv=0000 immediately, before the next clk edge.
- SUBS then B.cond GE: SUBS with flags {N=0,Z=1,C=1,V=0} (e.g. 5-5), then B.cond cond=1010 on the next cycle -> flags_nzcv=0110 one cycle after SUBS; mem_branch_taken=1 for the branch. Repeat with LT -> 0.
- Stall hold: advance ADD result 0x7FFFFFFFFFFFFFFF, then stall=1 for 3 cycles while inputs change -> mem_alu_result and flags unchanged. A flag-setter held in EX during the stall does not write the flags.
- Flush priority: stall=1 and flush=1 together with ex_valid=1, ex_set_flags=1, ex_mem_write=1 -> next cycle mem_valid=0, mem_mem_write=0, flags unchanged.
- CBZ/CBNZ: alu_zero=1 with CBZ -> taken=1; the same with CBNZ -> 0. With ex_valid=0 -> taken=0.
- Condition sweep: cond_check over all 16 cond codes × 16 NZCV values -> matches the reference equations; AL and 1111 are always 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared LEGv8 pipeline types: branch kinds, ARM condition codes, ALU controls, flags.
package cpu_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_CBZ  = 2'b01,
        BR_CBNZ = 2'b10,
        BR_COND = 2'b11
    } br_type_t;

    typedef logic [3:0] cond_t;

    localparam cond_t EQ = 4'b0000;
    localparam cond_t NE = 4'b0001;
    localparam cond_t HS = 4'b0010;
    localparam cond_t LO = 4'b0011;
    localparam cond_t MI = 4'b0100;
    localparam cond_t PL = 4'b0101;
    localparam cond_t VS = 4'b0110;
    localparam cond_t VC = 4'b0111;
    localparam cond_t HI = 4'b1000;
    localparam cond_t LS = 4'b1001;
    localparam cond_t GE = 4'b1010;
    localparam cond_t LT = 4'b1011;
    localparam cond_t GT = 4'b1100;
    localparam cond_t LE = 4'b1101;
    localparam cond_t AL = 4'b1110;

    typedef logic [2:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_PASS_B   = 3'b000;
    localparam alu_ctrl_t ALU_ADD      = 3'b010;
    localparam alu_ctrl_t ALU_SUBTRACT = 3'b011;
    localparam alu_ctrl_t ALU_AND      = 3'b100;
    localparam alu_ctrl_t ALU_OR       = 3'b101;
    localparam alu_ctrl_t ALU_XOR      = 3'b110;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluator used for B.cond resolution.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       taken
);

    nzcv_t f;
    assign f = nzcv_t'(nzcv);

    always_comb begin
        taken = 1'b0;
        case (cond)
            EQ: taken = f.z;
            NE: taken = ~f.z;
            HS: taken = f.c;
            LO: taken = ~f.c;
            MI: taken = f.n;
            PL: taken = ~f.n;
            VS: taken = f.v;
            VC: taken = ~f.v;
            HI: taken = f.c & ~f.z;
            LS: taken = ~f.c | f.z;
            GE: taken = (f.n == f.v);
            LT: taken = (f.n != f.v);
            GT: taken = ~f.z & (f.n == f.v);
            LE: taken = f.z | (f.n != f.v);
            // AL and 4'b1111 both mean "always"; unconditional B uses AL.
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with the architectural NZCV flag register and branch resolution.
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_negative,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_carry_out,
    input  logic              ex_set_flags,
    input  logic [1:0]        ex_br_type,
    input  logic [3:0]        ex_cond,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_AW-1:0] mem_rd,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_branch_taken,
    output logic [3:0]        flags_nzcv
);

    nzcv_t    flags_q;
    br_type_t br_type;
    logic     cond_taken;
    logic     branch_taken;
    logic     advance;

    assign br_type = br_type_t'(ex_br_type);
    assign advance = ~stall & ~flush;

    // B.cond reads the registered flags, so a setter that also branches sees pre-update values.
    cond_check u_cond_check (
        .cond  (ex_cond),
        .nzcv  (flags_q),
        .taken (cond_taken)
    );

    always_comb begin
        branch_taken = 1'b0;
        case (br_type)
            BR_CBZ:  branch_taken = alu_zero;
            BR_CBNZ: branch_taken = ~alu_zero;
            BR_COND: branch_taken = cond_taken;
            default: branch_taken = 1'b0;
        endcase
        if (!ex_valid) begin
            branch_taken = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid        <= 1'b0;
            mem_alu_result   <= '0;
            mem_store_data   <= '0;
            mem_rd           <= '0;
            mem_reg_write    <= 1'b0;
            mem_mem_read     <= 1'b0;
            mem_mem_write    <= 1'b0;
            mem_branch_taken <= 1'b0;
        end else if (flush) begin
            mem_valid        <= 1'b0;
            mem_reg_write    <= 1'b0;
            mem_mem_read     <= 1'b0;
            mem_mem_write    <= 1'b0;
            mem_branch_taken <= 1'b0;
        end else if (!stall) begin
            mem_valid        <= ex_valid;
            mem_alu_result   <= alu_result;
            mem_store_data   <= ex_store_data;
            mem_rd           <= ex_rd;
            mem_reg_write    <= ex_reg_write;
            mem_mem_read     <= ex_mem_read;
            mem_mem_write    <= ex_mem_write;
            mem_branch_taken <= branch_taken;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
        end else if (advance && ex_valid && ex_set_flags) begin
            flags_q <= '{n: alu_negative, z: alu_zero, c: alu_carry_out, v: alu_overflow};
        end
    end

    assign flags_nzcv = flags_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed vector table, corner sequences, random vs model.
module tb_ex_mem_stage;

    localparam int DATA_W = 64;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              stall = 1'b0;
    logic              flush = 1'b0;
    logic              ex_valid = 1'b0;
    logic [DATA_W-1:0] alu_result = '0;
    logic              alu_negative = 1'b0;
    logic              alu_zero = 1'b0;
    logic              alu_overflow = 1'b0;
    logic              alu_carry_out = 1'b0;
    logic              ex_set_flags = 1'b0;
    logic [1:0]        ex_br_type = 2'b00;
    logic [3:0]        ex_cond = 4'h0;
    logic [DATA_W-1:0] ex_store_data = '0;
    logic [REG_AW-1:0] ex_rd = '0;
    logic              ex_reg_write = 1'b0;
    logic              ex_mem_read = 1'b0;
    logic              ex_mem_write = 1'b0;

    logic              mem_valid;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_store_data;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_reg_write;
    logic              mem_mem_read;
    logic              mem_mem_write;
    logic              mem_branch_taken;
    logic [3:0]        flags_nzcv;

    ex_mem_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .ex_valid         (ex_valid),
        .alu_result       (alu_result),
        .alu_negative     (alu_negative),
        .alu_zero         (alu_zero),
        .alu_overflow     (alu_overflow),
        .alu_carry_out    (alu_carry_out),
        .ex_set_flags     (ex_set_flags),
        .ex_br_type       (ex_br_type),
        .ex_cond          (ex_cond),
        .ex_store_data    (ex_store_data),
        .ex_rd            (ex_rd),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .mem_valid        (mem_valid),
        .mem_alu_result   (mem_alu_result),
        .mem_store_data   (mem_store_data),
        .mem_rd           (mem_rd),
        .mem_reg_write    (mem_reg_write),
        .mem_mem_read     (mem_mem_read),
        .mem_mem_write    (mem_mem_write),
        .mem_branch_taken (mem_branch_taken),
        .flags_nzcv       (flags_nzcv)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ARM ConditionHolds: base test from cond[3:1], inverted by cond[0] except for 1111.
    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = (n == v) && !z;
            default: r = 1'b1;
        endcase
        if (c[0] && c != 4'hF) r = !r;
        return r;
    endfunction

    task automatic clear_inputs();
        stall = 0; flush = 0; ex_valid = 0; alu_result = '0;
        alu_negative = 0; alu_zero = 0; alu_overflow = 0; alu_carry_out = 0;
        ex_set_flags = 0; ex_br_type = 2'b00; ex_cond = 4'h0; ex_store_data = '0;
        ex_rd = '0; ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
    endtask

    task automatic drive_flags(input logic [3:0] f);
        alu_negative = f[3]; alu_zero = f[2]; alu_carry_out = f[1]; alu_overflow = f[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        v;
        logic        sf;
        logic [3:0]  nzcv;
        logic [1:0]  br;
        logic [3:0]  cond;
        logic [63:0] res;
        logic        e_valid;
        logic        e_taken;
        logic [3:0]  e_flags;
    } vec_t;

    vec_t vecs[9];

    // Reference model state for the random phase
    logic        m_valid, m_rw, m_mr, m_mw, m_taken, m_dk;
    logic [3:0]  m_flags;
    logic [63:0] m_result, m_store;
    logic [4:0]  m_rd;

    initial begin
        //            v  sf nzcv     br     cond     result              valid taken flags
        vecs[0] = '{1, 1, 4'b0110, 2'b00, 4'b0000, 64'h0,              1, 0, 4'b0110}; // SUBS 5-5
        vecs[1] = '{1, 0, 4'b0000, 2'b11, 4'b1010, 64'h10,             1, 1, 4'b0110}; // B.GE
        vecs[2] = '{1, 0, 4'b0000, 2'b11, 4'b1011, 64'h20,             1, 0, 4'b0110}; // B.LT
        vecs[3] = '{1, 0, 4'b0100, 2'b01, 4'b0000, 64'h0,              1, 1, 4'b0110}; // CBZ zero
        vecs[4] = '{1, 0, 4'b0100, 2'b10, 4'b0000, 64'h0,              1, 0, 4'b0110}; // CBNZ zero
        vecs[5] = '{0, 0, 4'b0100, 2'b01, 4'b0000, 64'h0,              0, 0, 4'b0110}; // CBZ bubble
        vecs[6] = '{1, 0, 4'b0000, 2'b11, 4'b1110, 64'h30,             1, 1, 4'b0110}; // B (AL)
        vecs[7] = '{1, 1, 4'b0000, 2'b11, 4'b0000, 64'h40,             1, 1, 4'b0000}; // setter+B.EQ pre-flags
        vecs[8] = '{1, 0, 4'b0000, 2'b11, 4'b0000, 64'h50,             1, 0, 4'b0000}; // B.EQ new flags

        #2;
        chk("reset_valid", mem_valid, 0);
        chk("reset_flags", flags_nzcv, 0);
        chk("reset_taken", mem_branch_taken, 0);
        @(negedge clk);
        reset = 0;

        for (int i = 0; i < 9; i++) begin
            clear_inputs();
            ex_valid = vecs[i].v; ex_set_flags = vecs[i].sf; drive_flags(vecs[i].nzcv);
            ex_br_type = vecs[i].br; ex_cond = vecs[i].cond; alu_result = vecs[i].res;
            ex_reg_write = 1;
            tick();
            chk($sformatf("vec%0d_valid", i), mem_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d_taken", i), mem_branch_taken, vecs[i].e_taken);
            chk($sformatf("vec%0d_flags", i), flags_nzcv, vecs[i].e_flags);
            chk($sformatf("vec%0d_result", i), mem_alu_result, vecs[i].res);
        end

        // Asynchronous reset mid-cycle with a valid instruction in MEM
        clear_inputs();
        ex_valid = 1; alu_result = 64'hDEAD_BEEF_0000_0001; ex_store_data = 64'h1234;
        ex_rd = 5'd7; ex_reg_write = 1; ex_mem_read = 1; ex_mem_write = 1;
        ex_br_type = 2'b11; ex_cond = 4'hE; ex_set_flags = 1; drive_flags(4'b1011);
        tick();
        chk("pre_reset_valid", mem_valid, 1);
        #2 reset = 1;
        #1;
        chk("async_reset_valid", mem_valid, 0);
        chk("async_reset_result", mem_alu_result, 0);
        chk("async_reset_store", mem_store_data, 0);
        chk("async_reset_rd", mem_rd, 0);
        chk("async_reset_ctrl", {mem_reg_write, mem_mem_read, mem_mem_write}, 0);
        chk("async_reset_taken", mem_branch_taken, 0);
        chk("async_reset_flags", flags_nzcv, 0);
        stall = 1;
        #2 reset = 0;
        tick();
        chk("stall_after_reset_valid", mem_valid, 0);
        stall = 0;
        tick();
        chk("first_advance_valid", mem_valid, 1);
        chk("first_advance_flags", flags_nzcv, 4'b1011);

        // Stall hold, including a flag-setter held in EX
        clear_inputs();
        ex_valid = 1; alu_result = 64'h7FFF_FFFF_FFFF_FFFF;
        tick();
        chk("stall_pre_result", mem_alu_result, 64'h7FFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            stall = 1; ex_valid = 1; ex_set_flags = 1; drive_flags(4'b0100);
            alu_result = {$urandom, $urandom}; ex_mem_write = 1;
            tick();
            chk($sformatf("stall%0d_result", i), mem_alu_result, 64'h7FFF_FFFF_FFFF_FFFF);
            chk($sformatf("stall%0d_flags", i), flags_nzcv, 4'b1011);
            chk($sformatf("stall%0d_mw", i), mem_mem_write, 0);
        end

        // Flush beats stall and blocks the flag write
        clear_inputs();
        ex_valid = 1; ex_set_flags = 1; drive_flags(4'b1010);
        tick();
        chk("flush_pre_flags", flags_nzcv, 4'b1010);
        stall = 1; flush = 1; ex_valid = 1; ex_set_flags = 1; ex_mem_write = 1;
        drive_flags(4'b0101); ex_br_type = 2'b11; ex_cond = 4'hE;
        tick();
        chk("flush_valid", mem_valid, 0);
        chk("flush_mw", mem_mem_write, 0);
        chk("flush_taken", mem_branch_taken, 0);
        chk("flush_flags", flags_nzcv, 4'b1010);

        // Full condition sweep through the registered flags
        for (int f = 0; f < 16; f++) begin
            clear_inputs();
            ex_valid = 1; ex_set_flags = 1; drive_flags(f[3:0]);
            tick();
            chk($sformatf("sweep_flags_%0d", f), flags_nzcv, f[3:0]);
            for (int c = 0; c < 16; c++) begin
                clear_inputs();
                ex_valid = 1; ex_br_type = 2'b11; ex_cond = c[3:0];
                drive_flags(~f[3:0]);
                tick();
                chk($sformatf("sweep_c%0d_f%0d", c, f), mem_branch_taken, cond_ref(c[3:0], f[3:0]));
            end
        end

        // Random phase against the reference model
        clear_inputs();
        reset = 1;
        #3 reset = 0;
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_taken = 0; m_dk = 1;
        m_flags = 0; m_result = 0; m_store = 0; m_rd = 0;
        for (int i = 0; i < 600; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            ex_valid = ($urandom_range(0, 4) != 0);
            alu_result = {$urandom, $urandom};
            ex_store_data = {$urandom, $urandom};
            drive_flags(4'($urandom));
            ex_set_flags = $urandom_range(0, 1);
            ex_br_type = 2'($urandom);
            ex_cond = 4'($urandom);
            ex_rd = 5'($urandom);
            ex_reg_write = $urandom_range(0, 1);
            ex_mem_read = $urandom_range(0, 1);
            ex_mem_write = $urandom_range(0, 1);
            if (flush) begin
                m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_taken = 0; m_dk = 0;
            end else if (!stall) begin
                m_taken = 0;
                if (ex_valid) begin
                    case (ex_br_type)
                        2'b01: m_taken = alu_zero;
                        2'b10: m_taken = !alu_zero;
                        2'b11: m_taken = cond_ref(ex_cond, m_flags);
                        default: m_taken = 0;
                    endcase
                end
                m_valid = ex_valid; m_rw = ex_reg_write; m_mr = ex_mem_read; m_mw = ex_mem_write;
                m_result = alu_result; m_store = ex_store_data; m_rd = ex_rd; m_dk = 1;
                if (ex_valid && ex_set_flags)
                    m_flags = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
            end
            tick();
            chk("rnd_valid", mem_valid, m_valid);
            chk("rnd_ctrl", {mem_reg_write, mem_mem_read, mem_mem_write}, {m_rw, m_mr, m_mw});
            chk("rnd_taken", mem_branch_taken, m_taken);
            chk("rnd_flags", flags_nzcv, m_flags);
            if (m_dk) begin
                chk("rnd_result", mem_alu_result, m_result);
                chk("rnd_store", mem_store_data, m_store);
                chk("rnd_rd", mem_rd, m_rd);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
